// File: rtl/tc_register_arbiter_if.sv
// Bundle of requester handshake and shared-register pins for tc_register_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the register.
interface tc_register_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BIT_WIDTH = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [BIT_WIDTH-1:0]         rsp_data;
    logic                         busy;
    logic                         reg_save;
    logic                         reg_load;
    logic [BIT_WIDTH-1:0]         reg_in;
    logic [BIT_WIDTH-1:0]         reg_out;

    modport slave (
        input  req, req_we, req_wdata, reg_out,
        output gnt, rsp_valid, rsp_data, busy, reg_save, reg_load, reg_in
    );

    modport master (
        output req, req_we, req_wdata, reg_out,
        input  gnt, rsp_valid, rsp_data, busy, reg_save, reg_load, reg_in
    );
endinterface

// File: rtl/tc_register_arbiter.sv
// Round-robin arbiter sharing one save/load register among NUM_REQ requesters.
// Writes take one save cycle; reads take a load cycle then a return cycle.
module tc_register_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tc_register_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StLoad, StReturn} state_e;

    state_e               state_q;
    logic [IdxW-1:0]      ptr_q;
    logic [IdxW-1:0]      win_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [BIT_WIDTH-1:0] rsp_data_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;

    logic                 found;
    logic [IdxW-1:0]      pick;
    logic [IdxW-1:0]      cand;
    int unsigned          idx;
    logic [BIT_WIDTH-1:0] pick_data;

    // Search ptr+1, ptr+2, ... wrapping; ptr itself is visited last.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx  = (32'(ptr_q) + k) % NUM_REQ;
            cand = IdxW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_data = bus.req_wdata[32'(pick) * BIT_WIDTH +: BIT_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= LastIdx;
            win_q       <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                StIdle: begin
                    if (found) begin
                        win_q       <= pick;
                        ptr_q       <= pick;
                        wdata_q     <= pick_data;
                        gnt_q[pick] <= 1'b1;
                        state_q     <= bus.req_we[pick] ? StWrite : StLoad;
                    end
                end
                StWrite: state_q <= StIdle;
                StLoad:  state_q <= StReturn;
                StReturn: begin
                    rsp_data_q         <= bus.reg_out;
                    rsp_valid_q[win_q] <= 1'b1;
                    state_q            <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Register-side strobes decode from state alone so req never reaches them combinationally.
    always_comb begin
        bus.gnt       = gnt_q;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_data  = rsp_data_q;
        bus.busy      = (state_q != StIdle);
        bus.reg_save  = (state_q == StWrite);
        bus.reg_load  = (state_q == StLoad);
        bus.reg_in    = (state_q == StWrite) ? wdata_q : '0;
    end
endmodule

// File: tb/tb_tc_register_arbiter.sv
// Bench for tc_register_arbiter: a transaction table plus hand sequences, checked by a
// scoreboard monitor against a behavioural save/load register.
module tb_tc_register_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tc_register_arbiter_if #(.NUM_REQ(N), .BIT_WIDTH(W)) bus ();

    tc_register_arbiter #(.NUM_REQ(N), .BIT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared register: save captures in; load presents the stored value for one cycle.
    logic [W-1:0] stored = '0;
    logic [W-1:0] out_q  = '0;
    assign bus.reg_out = out_q;
    always @(posedge clk) begin
        if (bus.reg_save) stored <= bus.reg_in;
        out_q <= bus.reg_load ? stored : '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] gnt;
        logic         we;
        logic [W-1:0] data;
        int           gap;
    } exp_t;

    typedef struct {
        logic [N-1:0] who;
        logic [W-1:0] data;
        int           due;
    } rsp_t;

    typedef struct {
        int unsigned who;
        logic        we;
        logic [W-1:0] wdata;
        logic [W-1:0] exp;
    } vec_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   last_gnt = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i[1:0]] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        rsp_t r;
        logic save_exp;
        logic load_exp;
        save_exp = 1'b0;
        load_exp = 1'b0;
        if (!rst) begin
            rsp_q.delete();
        end else begin
            if (bus.gnt != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", 32'(bus.gnt), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt", 32'(bus.gnt), 32'(e.gnt));
                    if (e.gap != 0) check("gnt_gap", 32'(cyc - last_gnt), 32'(e.gap));
                    last_gnt = cyc;
                    if (e.we) begin
                        save_exp = 1'b1;
                        check("reg_in", 32'(bus.reg_in), 32'(e.data));
                    end else begin
                        load_exp = 1'b1;
                        r.who  = e.gnt;
                        r.data = e.data;
                        r.due  = cyc + 2;
                        rsp_q.push_back(r);
                    end
                end
            end
            check("reg_save", 32'(bus.reg_save), 32'(save_exp));
            check("reg_load", 32'(bus.reg_load), 32'(load_exp));
            if (bus.rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_valid", 32'(bus.rsp_valid), 32'(r.who));
                    check("rsp_data", 32'(bus.rsp_data), 32'(r.data));
                    check("rsp_latency", 32'(cyc), 32'(r.due));
                end
            end else if (rsp_q.size() != 0 && cyc > rsp_q[0].due) begin
                r = rsp_q.pop_front();
                check("rsp_missing", 32'(bus.rsp_valid), 32'(r.who));
            end
        end
    end

    // Requesters drop a request in the cycle its grant is visible.
    task automatic tick();
        @(negedge clk);
        bus.req = bus.req & ~bus.gnt;
    endtask

    task automatic settle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() != 0 || rsp_q.size() != 0 || bus.busy) && n < 40);
        if (n >= 40) begin
            check("settle_queue", 32'(exp_q.size()), 32'd0);
            check("settle_busy", 32'(bus.busy), 32'd0);
            exp_q.delete();
            bus.req = '0;
        end
        tick();
    endtask

    vec_t vecs[9];

    initial begin
        bit re;
        vecs[0] = '{0, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{0, 1'b0, 8'h00, 8'hA5};
        vecs[2] = '{2, 1'b1, 8'h5A, 8'h5A};
        vecs[3] = '{1, 1'b0, 8'h00, 8'h5A};
        vecs[4] = '{3, 1'b1, 8'hC3, 8'hC3};
        vecs[5] = '{3, 1'b0, 8'h00, 8'hC3};
        vecs[6] = '{1, 1'b1, 8'h0F, 8'h0F};
        vecs[7] = '{2, 1'b0, 8'h00, 8'h0F};
        vecs[8] = '{3, 1'b1, 8'h77, 8'h77};

        // Reset with random requests: every output quiet.
        bus.req       = 4'($urandom);
        bus.req_we    = 4'($urandom);
        bus.req_wdata = 32'($urandom);
        repeat (3) tick();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_reg_save", 32'(bus.reg_save), 32'd0);
        check("rst_reg_load", 32'(bus.reg_load), 32'd0);
        check("rst_reg_in", 32'(bus.reg_in), 32'd0);
        bus.req = '0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check("idle_gnt", 32'(bus.gnt), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Single-requester transactions from the table.
        foreach (vecs[i]) begin
            bus.req_we[vecs[i].who] = vecs[i].we;
            bus.req_wdata[vecs[i].who*W +: W] = vecs[i].wdata;
            exp_q.push_back('{oh(vecs[i].who), vecs[i].we, vecs[i].exp, 0});
            bus.req[vecs[i].who] = 1'b1;
            settle();
        end

        // All four read, requester 0 re-raises once: 0,1,2,3,0 every 3 cycles.
        bus.req_we = '0;
        exp_q.push_back('{oh(0), 1'b0, 8'h77, 0});
        exp_q.push_back('{oh(1), 1'b0, 8'h77, 3});
        exp_q.push_back('{oh(2), 1'b0, 8'h77, 3});
        exp_q.push_back('{oh(3), 1'b0, 8'h77, 3});
        bus.req = '1;
        re = 1'b0;
        for (int n = 0; n < 40 && !(re && exp_q.size() == 0); n++) begin
            tick();
            if (!re && bus.rsp_valid[0]) begin
                re = 1'b1;
                bus.req[0] = 1'b1;
                exp_q.push_back('{oh(0), 1'b0, 8'h77, 3});
            end
        end
        check("rr_reraised", 32'(re), 32'd1);
        settle();

        // After a grant to 0: write by 1 and read by 2 on the same edge.
        bus.req_we[0] = 1'b1;
        bus.req_wdata[0*W +: W] = 8'h11;
        exp_q.push_back('{oh(0), 1'b1, 8'h11, 0});
        bus.req[0] = 1'b1;
        settle();
        bus.req_we = 4'b0010;
        bus.req_wdata[1*W +: W] = 8'h3C;
        exp_q.push_back('{oh(1), 1'b1, 8'h3C, 0});
        exp_q.push_back('{oh(2), 1'b0, 8'h3C, 2});
        bus.req = 4'b0110;
        settle();

        // Wrap-around from ptr=3.
        bus.req_we = '0;
        exp_q.push_back('{oh(3), 1'b0, 8'h3C, 0});
        bus.req[3] = 1'b1;
        settle();
        exp_q.push_back('{oh(0), 1'b0, 8'h3C, 0});
        exp_q.push_back('{oh(3), 1'b0, 8'h3C, 3});
        bus.req = 4'b1001;
        settle();

        // Reset lands in the LOAD cycle of a read by requester 2.
        exp_q.push_back('{oh(2), 1'b0, 8'h3C, 0});
        bus.req[2] = 1'b1;
        for (int n = 0; n < 10 && !bus.gnt[2]; n++) tick();
        check("abort_gnt_seen", 32'(bus.gnt), 32'(oh(2)));
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_reg_load", 32'(bus.reg_load), 32'd0);
        check("abort_gnt", 32'(bus.gnt), 32'd0);
        bus.req = '0;
        exp_q.delete();
        repeat (2) tick();
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        repeat (2) tick();
        check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        exp_q.push_back('{oh(0), 1'b0, 8'h3C, 0});
        exp_q.push_back('{oh(2), 1'b0, 8'h3C, 3});
        bus.req = 4'b0101;
        settle();

        check("end_exp_q", 32'(exp_q.size()), 32'd0);
        check("end_rsp_q", 32'(rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "bench stopped at time limit");
    end
endmodule

// File: doc/tc_register_arbiter.md
# tc_register_arbiter

Round-robin controller that shares one register (save/load semantics, `BIT_WIDTH` wide) among `NUM_REQ` requesters. It drives the register's `save`/`load`/`in` pins and samples its `out`. It sequences each write as one save cycle and each read as a load followed by a return, so a read always observes the most recently completed write. It sits between the requesting units and a single shared register instance; it does not reset that register.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `BIT_WIDTH`, 8, data width of the shared register
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  per-requester request, held until granted
- `req_we`  in  NUM_REQ  1 = write, 0 = read; sampled at grant only
- `req_wdata`  in  NUM_REQ*BIT_WIDTH  write data, slice i = requester i; sampled at grant
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse on acceptance
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse carrying read data
- `rsp_data`  out  BIT_WIDTH  read data, valid while `rsp_valid` != 0
- `busy`  out  1  high when state != IDLE
- `reg_save`  out  1  to shared register `save`
- `reg_load`  out  1  to shared register `load`
- `reg_in`  out  BIT_WIDTH  to shared register `in`
- `reg_out`  in  BIT_WIDTH  from shared register `out`

## Operation
- States: IDLE, WRITE, LOAD, RETURN.
- IDLE: if any `req` bit is high, select the winner w by round robin. Latch w, `req_we[w]` and `req_wdata[w]`. Set `gnt[w]`=1 for the next cycle. Go to WRITE if we=1, else LOAD. If no request, stay in IDLE.
- Round robin: search starts at index `ptr+1` and increases, wrapping at NUM_REQ-1 to 0. `ptr` is the last granted index and updates at each grant. After reset `ptr` = NUM_REQ-1, so index 0 has first priority.
- WRITE: `reg_save`=1 and `reg_in`=latched wdata, both combinational from state. Next state is IDLE.
- LOAD: `reg_load`=1. Next state is RETURN.
- RETURN: `reg_out` now holds the stored value. At the exiting edge, `rsp_data`<=`reg_out` and `rsp_valid[w]`<=1. Next state is IDLE.
- `reg_in` = 0 outside WRITE. `reg_save` and `reg_load` are never high together.
- Requester rule: `req[i]` must be low at the first edge after the cycle in which `gnt[i]` is high. A requester whose request is still high is treated as a new request.
- `rsp_data` holds its last value when `rsp_valid` = 0.
- Reset (`rst`=0, at any time):
  - state = IDLE, `ptr` = NUM_REQ-1.
  - `gnt`, `rsp_valid`, `rsp_data`, `busy`, `reg_save`, `reg_load`, `reg_in` = 0.
  - An in-flight operation is dropped: no `rsp_valid`. A WRITE cut by reset may or may not have reached the register.

## Timing
- Edge E0: IDLE samples `req`. Cycle 1 (after E0): `gnt` pulse, state WRITE or LOAD, `busy`=1.
- Write: `reg_save` high in cycle 1; the register captures at E1. IDLE in cycle 2; the next grant is sampled at E2. Throughput is 2 cycles per write.
- Read: `reg_load` in cycle 1, RETURN in cycle 2, `rsp_valid`/`rsp_data` in cycle 3. IDLE in cycle 3, so a new request is sampled at E3 concurrently with the response. Throughput is 3 cycles per read.
- Write-then-read: a read granted right after a write (next grant at E2) loads in cycle 3 and returns the new data in cycle 5.
- No combinational path from `req` to any output. `reg_save`, `reg_load` and `reg_in` decode from the state register only.

## Test plan
- Reset: hold `rst`=0 with random `req` → all outputs 0, `busy`=0. Release, no `req` → stays IDLE, no pulses.
- Requester 0 writes 0xA5, then reads:
  - Write → `gnt`=0001 in cycle 1, `reg_save`=1 with `reg_in`=0xA5 in cycle 1.
  - Read → `gnt`=0001, then `rsp_valid`=0001 with `rsp_data`=0xA5 two cycles after `gnt`.
- All four requesters hold read requests, re-raising after each response → `gnt` order 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles. `reg_save` never asserts.
- After a grant to 0: requester 1 writes 0x3C while requester 2 reads, same edge → 1 granted first (`reg_in`=0x3C). Then 2 granted; `rsp_valid`=0100 with `rsp_data`=0x3C.
- Wrap-around: `ptr`=3, `req`=1001 → `gnt`=0001. With `req[3]` still high → next `gnt`=1000.
- Reset in LOAD (cycle 1 of a read by requester 2) → immediately IDLE, no `rsp_valid`. After release, `req`=0101 → `gnt`=0001 (`ptr` back to 3).
